// File: rtl/apb_req_queue_if.sv
// Command, APB-side and response signals of the APB request queue.
// The slave modport is the queue itself; master is whoever drives it.
interface apb_req_queue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       transfer;
  logic       read_write;
  logic [7:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] apb_read_paddr;
  logic       pready;
  logic [7:0] prdata;
  logic       rsp_valid;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] done_cnt;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, prdata,
    output cmd_ready, transfer, read_write,
    output apb_write_paddr, apb_write_data, apb_read_paddr,
    output rsp_valid, rsp_addr, rsp_data, busy, done_cnt
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, prdata,
    input  cmd_ready, transfer, read_write,
    input  apb_write_paddr, apb_write_data, apb_read_paddr,
    input  rsp_valid, rsp_addr, rsp_data, busy, done_cnt
  );
endinterface

// File: rtl/apb_req_queue.sv
// Command FIFO feeding an APB master, with a phase tracker that
// mirrors the master and returns read data as one-cycle responses.
module apb_req_queue #(
  parameter int DEPTH = 4
) (
  input logic            pclk,
  input logic            preset_n,
  apb_req_queue_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] P_IDLE   = 2'd0;
  localparam logic [1:0] P_SETUP  = 2'd1;
  localparam logic [1:0] P_ACCESS = 2'd2;

  logic          mem_w [DEPTH];
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    phase;
  logic [1:0]    phase_nxt;
  logic          rsp_valid;
  logic [7:0]    rsp_addr;
  logic [7:0]    rsp_data;
  logic [7:0]    done_cnt;

  logic          full;
  logic          has_head;
  logic          push;
  logic          done;
  logic          head_w;
  logic [7:0]    head_a;
  logic [7:0]    head_d;
  logic          xfer;

  assign full     = (count == CW'(DEPTH));
  assign has_head = (count != '0);
  assign push     = bus.cmd_valid && !full;
  assign done     = (phase == P_ACCESS) && bus.pready;

  assign head_w = mem_w[rd_ptr];
  assign head_a = mem_a[rd_ptr];
  assign head_d = mem_d[rd_ptr];

  always_comb begin
    xfer      = 1'b0;
    phase_nxt = phase;
    unique case (1'b1)
      (phase == P_IDLE): begin
        xfer = has_head;
        if (has_head) phase_nxt = P_SETUP;
      end
      (phase == P_SETUP): begin
        xfer      = 1'b1;
        phase_nxt = P_ACCESS;
      end
      (phase == P_ACCESS): begin
        xfer = 1'b1;
        // Pre-push count decides reissue; a new push waits in P_IDLE.
        if (done) begin
          xfer      = (count >= CW'(2));
          phase_nxt = xfer ? P_SETUP : P_IDLE;
        end
      end
      default: phase_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push) begin
      mem_w[wr_ptr] <= bus.cmd_write;
      mem_a[wr_ptr] <= bus.cmd_addr;
      mem_d[wr_ptr] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      phase     <= P_IDLE;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      done_cnt  <= '0;
    end else begin
      phase     <= phase_nxt;
      rsp_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (done) begin
        rd_ptr   <= rd_ptr + 1'b1;
        done_cnt <= done_cnt + 8'd1;
        if (!head_w) begin
          rsp_valid <= 1'b1;
          rsp_addr  <= head_a;
          rsp_data  <= bus.prdata;
        end
      end
      if (push && !done) count <= count + 1'b1;
      else if (!push && done) count <= count - 1'b1;
    end
  end

  assign bus.cmd_ready       = !full;
  assign bus.transfer        = xfer;
  assign bus.read_write      = has_head && head_w;
  assign bus.apb_write_paddr = (has_head && head_w) ? head_a : 8'd0;
  assign bus.apb_write_data  = (has_head && head_w) ? head_d : 8'd0;
  assign bus.apb_read_paddr  = (has_head && !head_w) ? head_a : 8'd0;
  assign bus.rsp_valid       = rsp_valid;
  assign bus.rsp_addr        = rsp_addr;
  assign bus.rsp_data        = rsp_data;
  assign bus.busy            = has_head || (phase != P_IDLE);
  assign bus.done_cnt        = done_cnt;
endmodule

// File: doc/apb_req_queue.md
APB_REQ_QUEUE -- requirements
Module: apb_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; SHALL be a power of two, >= 2.
REQ-002 pclk  in  1  sole clock, all state updates on rising edge.
REQ-003 preset_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  requester offers a command.
REQ-005 cmd_ready  out  1  queue can accept; equals (count != DEPTH).
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  8  target address.
REQ-008 cmd_wdata  in  8  write data; ignored for reads.
REQ-009 transfer  out  1  drives the APB master's transfer input.
REQ-010 read_write  out  1  head-entry direction to the master.
REQ-011 apb_write_paddr  out  8  head address when head is a write, else 0.
REQ-012 apb_write_data  out  8  head write data when head is a write, else 0.
REQ-013 apb_read_paddr  out  8  head address when head is a read, else 0.
REQ-014 pready  in  1  slave ready, as seen by the master.
REQ-015 prdata  in  8  slave read data.
REQ-016 rsp_valid  out  1  one-cycle pulse: read completed.
REQ-017 rsp_addr  out  8  address of the completed read.
REQ-018 rsp_data  out  8  data of the completed read.
REQ-019 busy  out  1  high when FIFO non-empty or phase != P_IDLE.
REQ-020 done_cnt  out  8  completed-transaction count, reads and writes.

Function
REQ-021 Push occurs when cmd_valid && cmd_ready; entry {write, addr, wdata} stored at wr_ptr; wr_ptr wraps modulo DEPTH.
REQ-022 Pop occurs only on completion (REQ-026); rd_ptr wraps modulo DEPTH.
REQ-023 count SHALL be in 0..DEPTH; simultaneous push and pop leave count unchanged; push when full is ignored (cmd_ready=0).
REQ-024 Phase tracker mirrors the master: states P_IDLE, P_SETUP, P_ACCESS.
REQ-025 P_IDLE: transfer = (count != 0); if count != 0 go to P_SETUP, else stay.
REQ-026 P_SETUP: transfer = 1; always go to P_ACCESS. P_ACCESS: completion = pready; without pready stay in P_ACCESS.
REQ-027 P_ACCESS on completion: transfer = (count >= 2); go to P_SETUP if count >= 2, else P_IDLE; a push on the completion cycle does not cause back-to-back issue.
REQ-028 Head outputs (REQ-010..013) SHALL remain stable from P_SETUP entry until the completion cycle inclusive; a push never alters the head entry.
REQ-029 pready in P_IDLE or P_SETUP SHALL be ignored; no pop, no response.
REQ-030 Completion of a read: next cycle rsp_valid=1, rsp_addr=head addr, rsp_data=prdata sampled on the completion cycle; otherwise rsp_valid=0 and rsp_addr/rsp_data hold.
REQ-031 Completion of a write: no response; done_cnt increments by 1 for every completion, wrapping 255 -> 0.
REQ-032 Empty FIFO in P_IDLE: transfer=0, all head outputs 0.

Reset
REQ-033 While preset_n=0 at a rising edge: count=0, pointers=0, phase=P_IDLE, rsp_valid=0, rsp_addr=0, rsp_data=0, done_cnt=0; FIFO storage not cleared.
REQ-034 Reset mid-transaction discards all queued and in-flight commands; no response issued for them.
REQ-035 Outputs after reset: cmd_ready=1, transfer=0, busy=0, head outputs 0.

Verification
REQ-036 Single write {addr 0x10, data 0xA5}, zero-wait slave -> transfer high 1 cycle in P_IDLE, completion 3 cycles after push, done_cnt=1, no rsp_valid.
REQ-037 Write 0x3C to 0x20 then read 0x20 queued back-to-back -> second issue enters P_SETUP directly from P_ACCESS, rsp_valid pulse with rsp_addr=0x20, rsp_data=0x3C.
REQ-038 Push DEPTH commands while slave holds pready=0 -> cmd_ready=0 after 4th push, 5th push ignored, head outputs stable throughout wait.
REQ-039 Push and completion on same cycle with count=1 -> count stays 1, phase goes P_IDLE then P_SETUP next cycle.
REQ-040 preset_n low during P_ACCESS of a queued read -> count=0, no rsp_valid, busy=0 next cycle.
REQ-041 256 writes completed -> done_cnt wraps to 0.
